// File: rtl/shift_reg_seq.sv
// Sequencer for an external shift register: FILL streams elements in as writes,
// DRAIN reads/rotates them out as a stream. Optional error flag: SHIFT_REG_SEQ_ERR_EN.
module shift_reg_seq #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LENGTH     = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mode,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [1:0]            ctrl_code,
   output logic [DATA_WIDTH-1:0] data_write,
   input  logic [DATA_WIDTH-1:0] data_read,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int unsigned      CNT_W      = $clog2(LENGTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LENGTH - 1);
   localparam logic [1:0]       CMD_UPLOAD = 2'd0;
   localparam logic [1:0]       CMD_WRITE  = 2'd2;
   localparam logic [1:0]       CMD_READ   = 2'd3;

   typedef enum logic [2:0] {
      IDLE, FILL, UPLOAD, RD_CMD, RD_WAIT, RD_CAP, OUT, DONE
   } state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [1:0]            ctrl_code_nxt;
   logic [DATA_WIDTH-1:0] data_write_nxt, m_data_nxt;
   logic                  s_ready_nxt, m_valid_nxt, busy_nxt, done_nxt;
   logic                  fill_beat, out_beat;

   assign fill_beat = (state == FILL) && s_valid && s_ready;
   assign out_beat  = (state == OUT) && m_valid && m_ready;

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         ctrl_code  <= CMD_UPLOAD;
         data_write <= '0;
         m_data     <= '0;
         m_valid    <= 1'b0;
         s_ready    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         ctrl_code  <= ctrl_code_nxt;
         data_write <= data_write_nxt;
         m_data     <= m_data_nxt;
         m_valid    <= m_valid_nxt;
         s_ready    <= s_ready_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   // Next state; counter counts accepted beats / emitted elements and stops at LENGTH
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               cnt_nxt   = '0;
               state_nxt = mode ? RD_CMD : FILL;
            end
         end
         FILL: begin
            if (fill_beat) begin
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == CNT_LAST) state_nxt = UPLOAD;
            end
         end
         UPLOAD:  state_nxt = DONE;
         RD_CMD:  state_nxt = RD_WAIT;
         RD_WAIT: state_nxt = RD_CAP;
         RD_CAP:  state_nxt = OUT;
         OUT: begin
            if (out_beat) begin
               cnt_nxt   = cnt + CNT_W'(1);
               state_nxt = (cnt == CNT_LAST) ? DONE : RD_CMD;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output next values; status flags follow the state being entered
   always_comb begin
      ctrl_code_nxt  = CMD_UPLOAD;
      data_write_nxt = data_write;
      m_data_nxt     = m_data;
      s_ready_nxt    = (state_nxt == FILL);
      m_valid_nxt    = (state_nxt == OUT);
      busy_nxt       = (state_nxt != IDLE);
      done_nxt       = (state_nxt == DONE);
      if (fill_beat) begin
         ctrl_code_nxt  = CMD_WRITE;
         data_write_nxt = s_data;
      end
      if (state_nxt == RD_CMD) ctrl_code_nxt = CMD_READ;
      if (state == RD_CAP)     m_data_nxt    = data_read;
   end

`ifdef SHIFT_REG_SEQ_ERR_EN
   // Sticky flag: a start request arrived while an operation was running
   always_ff @(posedge clock) begin
      if (reset)               err <= 1'b0;
      else if (start && busy)  err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: table vectors, corner sequences and random ops checked
// against a queue-based model of the external shift register contents.
module tb_shift_reg_seq;
   localparam int unsigned W   = 8;
   localparam int unsigned L   = 4;
   localparam int          TMO = 64;
`ifdef SHIFT_REG_SEQ_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset, start, mode, s_valid, s_ready, m_valid, m_ready, busy, done, err;
   logic [W-1:0] s_data, m_data, data_write;
   logic [W-1:0] data_read = '0;
   logic [1:0]   ctrl_code;

   int checks = 0;
   int failures = 0;
   bit exp_err = 1'b0;

   always #5 clock = ~clock;

   shift_reg_seq #(.DATA_WIDTH(W), .LENGTH(L)) dut (
      .clock(clock), .reset(reset), .start(start), .mode(mode),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .ctrl_code(ctrl_code), .data_write(data_write), .data_read(data_read),
      .busy(busy), .done(done), .err(err)
   );

   // External shift register: write shifts in at the top, read emits slot 0 and rotates
   logic [W-1:0]   slot [L];
   logic [W*L-1:0] data_out = '0;
   logic [W-1:0]   wr_log [$];
   int n_reads = 0, n_done = 0, n_code1 = 0, n_viol = 0;

   initial for (int i = 0; i < L; i++) slot[i] = '0;

   always @(posedge clock) begin
      case (ctrl_code)
         2'd2: begin
            for (int i = 0; i < L - 1; i++) slot[i] <= slot[i+1];
            slot[L-1] <= data_write;
            wr_log.push_back(data_write);
         end
         2'd3: begin
            data_read <= slot[0];
            for (int i = 0; i < L - 1; i++) slot[i] <= slot[i+1];
            slot[L-1] <= slot[0];
            n_reads++;
         end
         2'd1: n_code1++;
         default: for (int i = 0; i < L; i++) data_out[i*W +: W] <= slot[i];
      endcase
      if (done) n_done++;
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (!busy && (s_ready || m_valid || done)) n_viol++;
         if (s_ready && m_valid) n_viol++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_done_and_finish(input string tag, input int base_done);
      int t;
      t = 0;
      while (!done && t < TMO) begin tick(); t++; end
      check({tag, "_done"}, done, 1);
      tick();
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_done_count"}, n_done - base_done, 1);
      check({tag, "_err"}, err, exp_err);
   endtask

   task automatic do_fill(input logic [W*L-1:0] w, input int gap, input bit rnd,
                          input logic [W*L-1:0] exp_out);
      int t, g, base_done;
      logic [W*L-1:0] got;
      wr_log.delete();
      base_done = n_done;
      mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < L; i++) begin
         g = rnd ? int'($urandom_range(3, 0)) : ((i == 0) ? 0 : gap);
         s_valid = 1'b0;
         repeat (g) tick();
         s_valid = 1'b1;
         s_data  = w[i*W +: W];
         t = 0;
         while (!s_ready && t < TMO) begin tick(); t++; end
         check("fill_ready", s_ready, 1);
         tick();
      end
      s_valid = 1'b0;
      check("fill_ready_low_after_last", s_ready, 0);
      wait_done_and_finish("fill", base_done);
      got = '0;
      for (int i = 0; i < wr_log.size() && i < L; i++) got[i*W +: W] = wr_log[i];
      check("fill_write_count", wr_log.size(), L);
      check("fill_write_data", got, w);
      check("fill_data_out", data_out, exp_out);
   endtask

   task automatic do_drain(input logic [W*L-1:0] exp, input int stall_idx, input int stall_n,
                           input bit rnd, input bit poke);
      int t, n_st, base_rd, base_done, rd0;
      logic [W-1:0] held;
      base_rd = n_reads;
      base_done = n_done;
      m_ready = 1'b0; mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < L; i++) begin
         t = 0;
         while (!m_valid && t < TMO) begin tick(); t++; end
         check("drain_valid", m_valid, 1);
         check("drain_data", m_data, exp[i*W +: W]);
         if (poke && i == 0) begin
            start = 1'b1; mode = 1'b0; tick(); start = 1'b0;
            exp_err = exp_err | ERR_EN;
            check("poke_err", err, exp_err);
            check("poke_still_out", m_valid, 1);
         end
         held = m_data;
         rd0  = n_reads;
         n_st = rnd ? int'($urandom_range(3, 0)) : ((i == stall_idx) ? stall_n : 0);
         for (int k = 0; k < n_st; k++) begin
            tick();
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, held);
            check("stall_no_read", n_reads - rd0, 0);
         end
         m_ready = 1'b1; tick(); m_ready = 1'b0;
      end
      wait_done_and_finish("drain", base_done);
      check("drain_read_count", n_reads - base_rd, L);
      check("drain_data_out_restored", data_out, exp);
   endtask

   typedef struct {
      bit             mode;
      logic [W*L-1:0] word;
      int             gap;
      int             stall_idx;
      int             stall_n;
      bit             poke;
      logic [W*L-1:0] exp_out;
   } vec_t;

   vec_t           tbl [6];
   logic [W-1:0]   ref_q [$];
   logic [W*L-1:0] w, e;

   initial begin
      tbl[0] = '{1'b0, 32'h44332211, 0, -1, 0, 1'b0, 32'h44332211};
      tbl[1] = '{1'b1, 32'h0,        0, -1, 0, 1'b0, 32'h44332211};
      tbl[2] = '{1'b1, 32'h0,        0,  1, 5, 1'b0, 32'h44332211};
      tbl[3] = '{1'b0, 32'hD4C3B2A1, 2, -1, 0, 1'b0, 32'hD4C3B2A1};
      tbl[4] = '{1'b1, 32'h0,        0, -1, 0, 1'b1, 32'hD4C3B2A1};
      tbl[5] = '{1'b1, 32'h0,        0,  3, 2, 1'b0, 32'hD4C3B2A1};

      reset = 1'b1; start = 1'b0; mode = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      repeat (2) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ctrl", ctrl_code, 0);
      check("rst_dwrite", data_write, 0);
      check("rst_mdata", m_data, 0);
      check("rst_mvalid", m_valid, 0);
      check("rst_sready", s_ready, 0);
      check("rst_err", err, 0);
      reset = 1'b0;
      tick();

      for (int v = 0; v < 6; v++) begin
         if (!tbl[v].mode) do_fill(tbl[v].word, tbl[v].gap, 1'b0, tbl[v].exp_out);
         else do_drain(tbl[v].exp_out, tbl[v].stall_idx, tbl[v].stall_n, 1'b0, tbl[v].poke);
      end

      // Reset in the middle of a fill, then a clean fill and drain
      mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
      s_valid = 1'b1; s_data = 8'h5A; tick();
      s_data = 8'h5B; tick();
      s_valid = 1'b0;
      begin
         int base;
         base = n_done;
         reset = 1'b1; tick();
         check("mid_rst_busy", busy, 0);
         check("mid_rst_sready", s_ready, 0);
         check("mid_rst_ctrl", ctrl_code, 0);
         check("mid_rst_dwrite", data_write, 0);
         check("mid_rst_mdata", m_data, 0);
         check("mid_rst_mvalid", m_valid, 0);
         check("mid_rst_done", done, 0);
         check("mid_rst_err", err, 0);
         reset = 1'b0; exp_err = 1'b0;
         repeat (4) tick();
         check("mid_rst_no_done", n_done - base, 0);
      end
      do_fill(32'h87654321, 1, 1'b0, 32'h87654321);
      do_drain(32'h87654321, -1, 0, 1'b0, 1'b0);

      // Random operations against the queue model of register contents
      for (int n = 0; n < 16; n++) begin
         if (n == 0 || $urandom_range(1, 0) == 0) begin
            w = W*L'($urandom());
            ref_q.delete();
            for (int i = 0; i < L; i++) ref_q.push_back(w[i*W +: W]);
            do_fill(w, 0, 1'b1, w);
         end else begin
            e = '0;
            for (int i = 0; i < L; i++) e[i*W +: W] = ref_q[i];
            do_drain(e, -1, 0, 1'b1, ($urandom_range(3, 0) == 0));
         end
      end

      check("never_code1", n_code1, 0);
      check("handshake_outside_state", n_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shift_reg_seq.md
SHIFT_REG_SEQ -- requirements
Module: shift_reg_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter LENGTH, default 4, number of elements in the downstream shift register (min 2).
REQ-003 SHALL have port clock  in  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle operation request, sampled only in IDLE.
REQ-006 SHALL have port mode  in  1  operation select, sampled with start: 0 = FILL, 1 = DRAIN.
REQ-007 SHALL have ports s_valid/s_ready (in/out, 1), s_data (in, DATA_WIDTH)  input element stream.
REQ-008 SHALL have ports m_valid (out, 1), m_ready (in, 1), m_data (out, DATA_WIDTH)  output element stream.
REQ-009 SHALL have port ctrl_code  out  2  shift-register command: 0 upload, 1 load, 2 write, 3 read.
REQ-010 SHALL have port data_write  out  DATA_WIDTH  element paired with ctrl_code 2.
REQ-011 SHALL have port data_read  in  DATA_WIDTH  shift-register read data, valid the cycle after a read command.
REQ-012 SHALL have ports busy, done, err  out, 1 each  status.

Function
REQ-013 SHALL implement the FSM states IDLE, FILL, UPLOAD, RD_CMD, RD_WAIT, RD_CAP, OUT, DONE.
REQ-014 SHALL register ctrl_code and data_write, and SHALL drive ctrl_code 0 (upload, harmless) whenever no write or read is issued; code 1 is never driven.
REQ-015 IDLE: start with mode 0 -> FILL, with mode 1 -> RD_CMD; start is ignored in every other state; busy = 1 in every state except IDLE.
REQ-016 FILL: s_ready = 1; each s_valid&&s_ready beat at cycle t SHALL produce ctrl_code 2 and data_write = s_data in cycle t+1, a counter incrementing 0..LENGTH-1.
REQ-017 FILL SHALL accept exactly LENGTH beats, deassert s_ready from the cycle after the last beat, then go to UPLOAD; gaps in s_valid insert ctrl_code 0 cycles.
REQ-018 The first accepted element SHALL end in slot 0 (LSBs) of the register, the last in slot LENGTH-1.
REQ-019 UPLOAD: one cycle of ctrl_code 0 so the register's parallel output reflects the fill, then DONE.
REQ-020 RD_CMD: ctrl_code 3 for one cycle; RD_WAIT: one cycle with ctrl_code 0; RD_CAP: capture data_read into m_data; OUT: m_valid = 1 holding m_data stable until m_ready.
REQ-021 On m_valid&&m_ready, the FSM SHALL return to RD_CMD if fewer than LENGTH elements have been emitted, else go to DONE.
REQ-022 DRAIN SHALL emit slot 0 first through slot LENGTH-1 last; after LENGTH reads the register contents are restored by rotation.
REQ-023 DONE: done = 1 for exactly one cycle, then IDLE.
REQ-024 s_ready SHALL be 0 outside FILL; m_valid SHALL be 0 outside OUT.
REQ-025 The element counter SHALL be clog2(LENGTH)+1 bits wide and SHALL not wrap during an operation.

Reset
REQ-026 Reset SHALL force IDLE, counter 0, ctrl_code 0, data_write 0, m_data 0, m_valid 0, s_ready 0, busy 0, done 0, err 0, in the cycle after reset is sampled high.
REQ-027 Reset mid-operation SHALL abandon the operation without a done pulse; a partially filled register is not cleared by this block.

Configuration
REQ-028 With SHIFT_REG_SEQ_ERR_EN defined: err SHALL be sticky, set when start is sampled high with busy = 1, cleared only by reset.
REQ-029 Without SHIFT_REG_SEQ_ERR_EN: err SHALL be tied 0 and no error logic synthesised; the port list is unchanged.

Verification
REQ-030 Fill: LENGTH=4, start mode 0, s_data 0x11,0x22,0x33,0x44 back-to-back -> ctrl_code 2 for 4 cycles with those data_write values, one upload cycle, done pulse; register data_out = 0x44332211.
REQ-031 Fill with gaps: s_valid low 2 cycles between beats -> ctrl_code 0 in the gap cycles; exactly 4 writes issued; s_ready low after the 4th beat.
REQ-032 Drain: register holds 0x44332211, start mode 1, m_ready = 1 -> m_data 0x11,0x22,0x33,0x44 in order, done pulse, register data_out again 0x44332211 after upload.
REQ-033 Drain backpressure: m_ready low 5 cycles on the 2nd element -> m_valid held, m_data = 0x22 stable, no further ctrl_code 3 until accepted.
REQ-034 Reset mid-FILL after 2 beats -> next cycle IDLE, all outputs 0, no done; a new fill then completes normally.
REQ-035 With SHIFT_REG_SEQ_ERR_EN: start during DRAIN -> err = 1 and the drain is unaffected; without the macro, err stays 0.
